// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice scheduler: key scan, edge detect, slot allocation/steal
module voice_allocator #(
  parameter int NUM_KEYS   = 88,
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 7
) (
  input  logic                        iCLK,
  input  logic                        iRST,
  input  logic [NUM_KEYS-1:0]         iKEYS,
  output logic [NUM_VOICES-1:0]       oVOICE_ACTIVE,
  output logic [NUM_VOICES*KEY_W-1:0] oVOICE_KEY,
  output logic [NUM_VOICES-1:0]       oNOTE_ON,
  output logic                        oSTEAL,
  output logic                        oSCAN_WRAP
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int AGE_W  = $clog2(NUM_VOICES);
  localparam logic [KEY_W-1:0] LAST_IDX = KEY_W'(NUM_KEYS - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(NUM_VOICES - 1);

  logic [KEY_W-1:0]            idx;
  logic [NUM_KEYS-1:0]         prev_keys;
  logic [NUM_VOICES-1:0]       active;
  logic [NUM_VOICES*KEY_W-1:0] key_vec;
  logic [AGE_W-1:0]            ages [NUM_VOICES];
  logic [NUM_VOICES-1:0]       note_on;
  logic                        steal;
  logic                        scan_wrap;

  logic                        cur;
  logic                        prev;
  logic                        press_ev;
  logic                        rel_ev;
  logic                        free_found;
  logic [VIDX_W-1:0]           free_slot;
  logic [VIDX_W-1:0]           old_slot;
  logic [AGE_W-1:0]            old_age;
  logic [VIDX_W-1:0]           target;

  // Lowest free slot wins; otherwise the oldest slot, strict '>' keeps ties on the lowest index.
  always_comb begin
    cur        = iKEYS[idx];
    prev       = prev_keys[idx];
    press_ev   = cur & ~prev;
    rel_ev     = ~cur & prev;
    free_found = 1'b0;
    free_slot  = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!active[v] && !free_found) begin
        free_found = 1'b1;
        free_slot  = VIDX_W'(v);
      end
    end
    old_slot = '0;
    old_age  = ages[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (ages[v] > old_age) begin
        old_slot = VIDX_W'(v);
        old_age  = ages[v];
      end
    end
    target = free_found ? free_slot : old_slot;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      idx       <= '0;
      prev_keys <= '0;
      active    <= '0;
      key_vec   <= '0;
      note_on   <= '0;
      steal     <= 1'b0;
      scan_wrap <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) ages[v] <= '0;
    end else begin
      idx            <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      prev_keys[idx] <= cur;
      scan_wrap      <= (idx == LAST_IDX);
      note_on        <= '0;
      steal          <= press_ev & ~free_found;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (press_ev) begin
          if (VIDX_W'(v) == target) begin
            active[v]                   <= 1'b1;
            key_vec[v*KEY_W +: KEY_W]   <= idx;
            ages[v]                     <= '0;
            note_on[v]                  <= 1'b1;
          end else if (active[v] && ages[v] != AGE_MAX) begin
            ages[v] <= ages[v] + 1'b1;
          end
        end else if (rel_ev) begin
          if (active[v] && key_vec[v*KEY_W +: KEY_W] == idx) begin
            active[v] <= 1'b0;
            ages[v]   <= '0;
          end
        end
      end
    end
  end

  assign oVOICE_ACTIVE = active;
  assign oVOICE_KEY    = key_vec;
  assign oNOTE_ON      = note_on;
  assign oSTEAL        = steal;
  assign oSCAN_WRAP    = scan_wrap;

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst;
  logic [87:0] keys;
  logic [3:0]  voice_active;
  logic [27:0] voice_key;
  logic [3:0]  note_on;
  logic        steal;
  logic        scan_wrap;

  int checks = 0;
  int failures = 0;

  voice_allocator #(.NUM_KEYS(88), .NUM_VOICES(4), .KEY_W(7)) dut (
    .iCLK          (clk),
    .iRST          (rst),
    .iKEYS         (keys),
    .oVOICE_ACTIVE (voice_active),
    .oVOICE_KEY    (voice_key),
    .oNOTE_ON      (note_on),
    .oSTEAL        (steal),
    .oSCAN_WRAP    (scan_wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_note(output logic [3:0] n, output logic s, output int cyc);
    n = '0;
    s = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (note_on != 4'b0) begin
        n = note_on;
        s = steal;
        break;
      end
    end
  endtask

  task automatic wait_active(input logic [3:0] exp, output int cyc);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (voice_active == exp) break;
    end
  endtask

  task automatic sync_wrap();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (scan_wrap) break;
    end
  endtask

  task automatic press(input int k, input logic [3:0] exp_note, input logic exp_steal, input int slot);
    logic [3:0] n;
    logic       s;
    int         cyc;
    keys[k] = 1'b1;
    wait_note(n, s, cyc);
    check($sformatf("press%0d_note", k), n, exp_note);
    check($sformatf("press%0d_steal", k), s, exp_steal);
    check($sformatf("press%0d_key", k), voice_key[slot*7 +: 7], k);
  endtask

  task automatic monitor_quiet(input int ncyc, output int notes, output logic [3:0] act_or);
    notes = 0;
    act_or = '0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (note_on != 4'b0) notes++;
      act_or = act_or | (voice_active ^ 4'b0);
    end
  endtask

  initial begin
    logic [3:0] n;
    logic       s;
    int         cyc;
    int         notes;
    int         wraps;
    logic [3:0] act_or;
    logic       junk;

    rst  = 1'b1;
    keys = '0;

    // Reset state and single press
    do_reset();
    check("rst_active", voice_active, 4'b0);
    check("rst_key", voice_key, 28'h0);
    check("rst_note", note_on, 4'b0);
    check("rst_steal", steal, 1'b0);
    check("rst_wrap", scan_wrap, 1'b0);
    keys[40] = 1'b1;
    wait_note(n, s, cyc);
    check("t1_note", n, 4'b0001);
    check("t1_steal", s, 1'b0);
    check("t1_active", voice_active, 4'b0001);
    check("t1_key0", voice_key[6:0], 7'd40);
    check("t1_latency_ok", cyc <= 89, 1'b1);
    @(negedge clk);
    check("t1_note_one_cycle", note_on, 4'b0);

    // Fill, release, refill lowest free slot
    keys = '0;
    do_reset();
    press(39, 4'b0001, 1'b0, 0);
    press(42, 4'b0010, 1'b0, 1);
    press(45, 4'b0100, 1'b0, 2);
    press(48, 4'b1000, 1'b0, 3);
    check("t2_keys", voice_key, {7'd48, 7'd45, 7'd42, 7'd39});
    check("t2_full", voice_active, 4'b1111);
    keys[42] = 1'b0;
    wait_active(4'b1101, cyc);
    check("t2_release42", voice_active, 4'b1101);
    check("t2_key1_retained", voice_key[13:7], 7'd42);
    press(50, 4'b0010, 1'b0, 1);
    check("t2_refill_active", voice_active, 4'b1111);

    // Steal oldest, ignore release of stolen key, saturating ages
    keys = '0;
    do_reset();
    press(39, 4'b0001, 1'b0, 0);
    press(42, 4'b0010, 1'b0, 1);
    press(45, 4'b0100, 1'b0, 2);
    press(48, 4'b1000, 1'b0, 3);
    press(51, 4'b0001, 1'b1, 0);
    @(negedge clk);
    check("t3_steal_pulse", steal, 1'b0);
    keys[39] = 1'b0;
    monitor_quiet(180, notes, act_or);
    check("t3_stolen_release_notes", notes, 0);
    check("t3_stolen_release_active", voice_active, 4'b1111);
    check("t3_keys", voice_key, {7'd48, 7'd45, 7'd42, 7'd51});
    press(53, 4'b0010, 1'b1, 1);

    // Free-run scan wrap period
    keys = '0;
    do_reset();
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (scan_wrap) break;
    end
    check("t4_first_wrap", cyc, 88);
    wraps = 0;
    act_or = '0;
    junk = 1'b0;
    for (int i = 0; i < 176; i++) begin
      @(negedge clk);
      if (scan_wrap) wraps++;
      act_or = act_or | voice_active | note_on;
      junk = junk | steal;
      if (i == 86) check("t4_no_early_wrap", wraps, 0);
    end
    check("t4_wrap_at_88", scan_wrap, 1'b1);
    check("t4_wrap_count", wraps, 2);
    check("t4_idle_outputs", {act_or, junk}, 5'b0);

    // Reset mid-scan with keys held
    keys[40] = 1'b1;
    keys[41] = 1'b1;
    wait_active(4'b0011, cyc);
    check("t5_pre_active", voice_active, 4'b0011);
    sync_wrap();
    repeat (60) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_rst_outputs", {voice_active, note_on, steal, scan_wrap, voice_key}, 38'h0);
    wait_active(4'b0011, cyc);
    check("t5_reassigned", voice_active, 4'b0011);
    check("t5_keys", voice_key[13:0], {7'd41, 7'd40});
    check("t5_latency_ok", cyc <= 89, 1'b1);

    // Toggle within one pass is invisible
    press(44, 4'b0100, 1'b0, 2);
    sync_wrap();
    keys[44] = 1'b0;
    repeat (10) @(negedge clk);
    keys[44] = 1'b1;
    monitor_quiet(180, notes, act_or);
    check("t6_notes", notes, 0);
    check("t6_active", voice_active, 4'b0111);
    check("t6_keys", voice_key[20:0], {7'd44, 7'd41, 7'd40});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
